id_ex_operand_stage: RTL and testbench

// - ID/EX pipeline register feeding the ALU: latches decoded operands/control, resolves data hazards,

---
 rtl/alu_pkg.sv | 21 ++
 rtl/fwd_unit.sv | 49 ++++
 rtl/id_ex_operand_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants, forwarding-select encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int RADDR_W_DEFAULT = 5;

  // ALU opcodes, also decoded by the downstream ALU.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;

  // Operand source chosen by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register (EX/MEM beats MEM/WB beats RF).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs every cycle.
//
// Ports:
//   rs_addr / rf_data                     registered source address and RF read data
//   exmem_reg_write/rd_addr/result        EX/MEM writeback candidate
//   memwb_reg_write/rd_addr/result        MEM/WB writeback candidate
//   fwd_data                              resolved operand
module fwd_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT
) (
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    fwd_data
);

  fwd_sel_t fwd_sel;

  // A non-zero rd check on the producer side is enough to keep x0 from ever
  // being forwarded: rs_addr==0 can then never match.
  always_comb begin
    fwd_sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == rs_addr)) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == rs_addr)) begin
      fwd_sel = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_data = rf_data;
    case (fwd_sel)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_result;
      default:   fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, load-use bubble, operand-b mux.
// Latency: ID fields reach ALU inputs 1 cycle later; forwarding paths are 0 cycles.
// Backpressure: stall holds EX; hazard_stall (comb) asks ID/IF to hold while a bubble enters EX.
//
// Ports:
//   clk, rst_n (sync, active-low), stall, flush
//   id_*         decoded instruction from ID
//   exmem_*      EX/MEM writeback for forwarding;  memwb_* MEM/WB writeback for forwarding
//   hazard_stall load-use detected against the current ID instruction
//   ex_*, alu_a, alu_b, alu_control  registered EX state and resolved ALU operands
module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_use_imm,
  input  logic [3:0]         id_alu_control,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]    memwb_result,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [3:0]         alu_control,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_mem_read
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic               use_imm;
    logic [3:0]         alu_control;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
    logic               mem_read;
  } ex_regs_t;

  // All-zero bubble: valid/reg_write/mem_read low, opcode ADD, addresses x0.
  localparam ex_regs_t EX_BUBBLE = '0;

  ex_regs_t ex_q;
  ex_regs_t ex_d;
  ex_regs_t id_fields;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Load in EX whose rd is consumed by ID. rs2 only counts when it feeds the
  // ALU, so immediate-form instructions never stall on rs2.
  always_comb begin
    hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && id_valid &&
                   ((ex_q.rd_addr == id_rs1_addr) ||
                    ((ex_q.rd_addr == id_rs2_addr) && !id_use_imm));
  end

  always_comb begin
    id_fields             = EX_BUBBLE;
    id_fields.valid       = id_valid;
    id_fields.pc          = id_pc;
    id_fields.rs1_addr    = id_rs1_addr;
    id_fields.rs2_addr    = id_rs2_addr;
    id_fields.rs1_data    = id_rs1_data;
    id_fields.rs2_data    = id_rs2_data;
    id_fields.imm         = id_imm;
    id_fields.use_imm     = id_use_imm;
    id_fields.alu_control = id_alu_control;
    id_fields.rd_addr     = id_rd_addr;
    id_fields.reg_write   = id_reg_write;
    id_fields.mem_read    = id_mem_read;
  end

  // Flush beats stall so a redirect is never lost behind a memory stall.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = EX_BUBBLE;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (hazard_stall) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .rs_addr         (ex_q.rs1_addr),
    .rf_data         (ex_q.rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs1)
  );

  fwd_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .rs_addr         (ex_q.rs2_addr),
    .rf_data         (ex_q.rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs2)
  );

  always_comb begin
    alu_a         = fwd_rs1;
    alu_b         = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    ex_store_data = fwd_rs2;
    alu_control   = ex_q.alu_control;
    ex_valid      = ex_q.valid;
    ex_pc         = ex_q.pc;
    ex_rd_addr    = ex_q.rd_addr;
    ex_reg_write  = ex_q.reg_write;
    ex_mem_read   = ex_q.mem_read;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, issue, forwarding, load-use, stall/flush.
// Latency: checks 1 ns after each rising edge, or 1 ns after a combinational input change.
// Backpressure: exercised through stall, flush and the load-use bubble.
module tb_id_ex_operand_stage;
  import alu_pkg::*;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall;
  logic               flush;
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [RADDR_W-1:0] id_rs1_addr;
  logic [RADDR_W-1:0] id_rs2_addr;
  logic [XLEN-1:0]    id_rs1_data;
  logic [XLEN-1:0]    id_rs2_data;
  logic [XLEN-1:0]    id_imm;
  logic               id_use_imm;
  logic [3:0]         id_alu_control;
  logic [RADDR_W-1:0] id_rd_addr;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               exmem_reg_write;
  logic [RADDR_W-1:0] exmem_rd_addr;
  logic [XLEN-1:0]    exmem_result;
  logic               memwb_reg_write;
  logic [RADDR_W-1:0] memwb_rd_addr;
  logic [XLEN-1:0]    memwb_result;
  logic               hazard_stall;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [3:0]         alu_control;
  logic [XLEN-1:0]    ex_store_data;
  logic [RADDR_W-1:0] ex_rd_addr;
  logic               ex_reg_write;
  logic               ex_mem_read;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] tmp;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_control(id_alu_control),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [XLEN-1:0] pc, input logic [RADDR_W-1:0] rs1,
                       input logic [RADDR_W-1:0] rs2, input logic [XLEN-1:0] d1,
                       input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                       input logic use_imm, input logic [3:0] ctl,
                       input logic [RADDR_W-1:0] rd, input logic mem_read);
    id_valid       = 1'b1;
    id_pc          = pc;
    id_rs1_addr    = rs1;
    id_rs2_addr    = rs2;
    id_rs1_data    = d1;
    id_rs2_data    = d2;
    id_imm         = imm;
    id_use_imm     = use_imm;
    id_alu_control = ctl;
    id_rd_addr     = rd;
    id_reg_write   = 1'b1;
    id_mem_read    = mem_read;
  endtask

  initial begin
    stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd_addr = '0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd_addr = '0; memwb_result = '0;

    // Reset with a valid MUL presented on ID.
    rst_n = 0;
    issue(32'h40, 5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, ALU_MUL, 5'd9, 1'b0);
    step();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_alu_control", alu_control, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    rst_n = 1;

    // Plain register-register ADD.
    issue(32'h100, 5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, ALU_ADD, 5'd3, 1'b0);
    step();
    chk("add_valid", ex_valid, 1);
    chk("add_alu_a", alu_a, 10);
    chk("add_alu_b", alu_b, 20);
    tmp = alu_a + alu_b;
    chk("add_result", tmp, 30);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_rd", ex_rd_addr, 3);

    // Immediate SUB: b takes imm, store data still rs2.
    issue(32'h104, 5'd1, 5'd2, 32'd10, 32'd20, 32'd5, 1'b1, ALU_SUB, 5'd3, 1'b0);
    step();
    chk("subi_alu_b", alu_b, 5);
    chk("subi_store", ex_store_data, 20);
    chk("subi_ctl", alu_control, ALU_SUB);
    tmp = alu_a - alu_b;
    chk("subi_result", tmp, 5);

    // Forward priority on rs1=3, EX held by stall.
    issue(32'h108, 5'd3, 5'd4, 32'd7, 32'd9, 32'd0, 1'b0, ALU_ADD, 5'd6, 1'b0);
    step();
    stall = 1;
    exmem_reg_write = 1; exmem_rd_addr = 5'd3; exmem_result = 32'd100;
    memwb_reg_write = 1; memwb_rd_addr = 5'd3; memwb_result = 32'd200;
    #1 chk("fwd_exmem_wins", alu_a, 100);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", alu_a, 200);
    memwb_reg_write = 0;
    #1 chk("fwd_rf", alu_a, 7);
    stall = 0;

    // rs1=x0 never forwarded; rs2 picks up MEM/WB.
    issue(32'h10c, 5'd0, 5'd4, 32'd0, 32'd9, 32'd0, 1'b0, ALU_ADD, 5'd6, 1'b0);
    exmem_reg_write = 1; exmem_rd_addr = 5'd0; exmem_result = 32'd100;
    memwb_reg_write = 1; memwb_rd_addr = 5'd4; memwb_result = 32'd200;
    step();
    chk("fwd_x0_alu_a", alu_a, 0);
    chk("fwd_rs2_alu_b", alu_b, 200);
    chk("fwd_rs2_store", ex_store_data, 200);
    memwb_rd_addr = 5'd0;
    #1 chk("fwd_x0_rs2_rf", alu_b, 9);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Load-use on rs2: one bubble, then issue.
    issue(32'h200, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd5, 1'b1);
    step();
    chk("ld_mem_read", ex_mem_read, 1);
    issue(32'h204, 5'd6, 5'd5, 32'd1, 32'd2, 32'd0, 1'b0, ALU_SUB, 5'd7, 1'b0);
    #1 chk("lu_hazard", hazard_stall, 1);
    step();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctl", alu_control, 0);
    chk("lu_hazard_clear", hazard_stall, 0);
    step();
    chk("lu_issue_valid", ex_valid, 1);
    chk("lu_issue_pc", ex_pc, 32'h204);
    chk("lu_issue_ctl", alu_control, ALU_SUB);

    // Same pair with rs2 unused (immediate form): no stall.
    issue(32'h208, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd5, 1'b1);
    step();
    issue(32'h20c, 5'd6, 5'd5, 32'd1, 32'd2, 32'd3, 1'b1, ALU_SUB, 5'd7, 1'b0);
    #1 chk("imm_no_hazard", hazard_stall, 0);
    step();
    chk("imm_issue_pc", ex_pc, 32'h20c);
    chk("imm_issue_valid", ex_valid, 1);

    // Load to x0 never stalls.
    issue(32'h210, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd0, 1'b1);
    step();
    issue(32'h214, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd7, 1'b0);
    #1 chk("x0_no_hazard", hazard_stall, 0);

    // Stall for 3 cycles: EX holds, forwarding tracks EX/MEM.
    issue(32'h300, 5'd3, 5'd2, 32'd11, 32'd0, 32'd0, 1'b0, ALU_SUB, 5'd8, 1'b0);
    step();
    stall = 1;
    issue(32'h400, 5'd1, 5'd2, 32'd99, 32'd0, 32'd0, 1'b0, ALU_MUL, 5'd9, 1'b0);
    exmem_reg_write = 1; exmem_rd_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      exmem_result = 32'd50 + 32'(i);
      step();
      chk("stall_pc", ex_pc, 32'h300);
      chk("stall_ctl", alu_control, ALU_SUB);
      chk("stall_fwd", alu_a, 32'd50 + 32'(i));
    end
    flush = 1;
    step();
    chk("stall_flush_valid", ex_valid, 0);
    chk("stall_flush_ctl", alu_control, 0);
    chk("stall_flush_pc", ex_pc, 0);
    stall = 0; flush = 0; exmem_reg_write = 0;

    // Flush during a load-use hazard: a single bubble, then ID issues.
    issue(32'h500, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd5, 1'b1);
    step();
    issue(32'h504, 5'd5, 5'd0, 32'd4, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd7, 1'b0);
    #1 chk("fh_hazard", hazard_stall, 1);
    flush = 1;
    step();
    chk("fh_bubble", ex_valid, 0);
    chk("fh_hazard_clear", hazard_stall, 0);
    flush = 0;
    step();
    chk("fh_issue_valid", ex_valid, 1);
    chk("fh_issue_pc", ex_pc, 32'h504);

    // Reset while stalled with a valid MUL in EX.
    issue(32'h600, 5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, ALU_MUL, 5'd9, 1'b0);
    step();
    tmp = alu_a * alu_b;
    chk("mul_result", tmp, 200);
    chk("mul_ctl", alu_control, ALU_MUL);
    stall = 1; rst_n = 0;
    step();
    chk("rst_mid_valid", ex_valid, 0);
    chk("rst_mid_ctl", alu_control, 0);
    chk("rst_mid_alu_a", alu_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
